mem_port_arbiter: RTL

- Two-requester arbiter sharing one data-memory port between the IFU (read-only fetch) and the LSU (load/store).
- Sits between the IFU/LSU valid/ready interfaces and the single memory port, so the core can run multi-cycle fetch and memory access against one memory.
- Serves exactly one outstanding transaction at a time.
- Arbitrates ties round-robin and latches the winning request so memory sees stable inputs.

---
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IFU fetch and LSU
// load/store, one transaction in flight, round-robin on ties.
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_raddr,
   output logic                ifu_resp_valid,
   input  logic                ifu_resp_ready,
   output logic [DATA_W-1:0]   ifu_rdata,

   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_resp_valid,
   input  logic                lsu_resp_ready,
   output logic [DATA_W-1:0]   lsu_rdata,

   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_resp_valid,
   output logic                mem_resp_ready,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int MASK_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP
   } state_t;

   typedef enum logic {
      OWN_IFU,
      OWN_LSU
   } own_t;

   state_t            state_q, state_d;
   own_t              owner_q, owner_d;
   own_t              last_q, last_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wen_q, wen_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [MASK_W-1:0] wmask_q, wmask_d;

   logic gnt_ifu;
   logic gnt_lsu;
   logic owner_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= OWN_IFU;
         last_q  <= OWN_IFU;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
      end
   end

   // On a tie the requester that did not win last time gets the port.
   always_comb begin
      gnt_ifu = ifu_req_valid &&
                (!lsu_req_valid || last_q == OWN_LSU);
      gnt_lsu = lsu_req_valid &&
                (!ifu_req_valid || last_q == OWN_IFU);
      owner_rdy = (owner_q == OWN_LSU) ? lsu_resp_ready
                                       : ifu_resp_ready;
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      addr_d  = addr_q;
      wen_d   = wen_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;

      ifu_req_ready  = 1'b0;
      lsu_req_ready  = 1'b0;
      ifu_resp_valid = 1'b0;
      lsu_resp_valid = 1'b0;
      mem_req_valid  = 1'b0;
      mem_resp_ready = 1'b0;

      unique case (state_q)
         IDLE: begin
            ifu_req_ready = gnt_ifu;
            lsu_req_ready = gnt_lsu;
            if (gnt_lsu) begin
               owner_d = OWN_LSU;
               addr_d  = lsu_addr;
               wen_d   = lsu_wen;
               wdata_d = lsu_wdata;
               wmask_d = lsu_wmask;
               state_d = REQ;
            end else if (gnt_ifu) begin
               owner_d = OWN_IFU;
               addr_d  = ifu_raddr;
               wen_d   = 1'b0;
               wdata_d = '0;
               wmask_d = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               state_d = RESP;
            end
         end
         RESP: begin
            mem_resp_ready = owner_rdy;
            ifu_resp_valid = (owner_q == OWN_IFU) && mem_resp_valid;
            lsu_resp_valid = (owner_q == OWN_LSU) && mem_resp_valid;
            if (mem_resp_valid && owner_rdy) begin
               last_d  = owner_q;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mem_addr  = addr_q;
   assign mem_wen   = wen_q;
   assign mem_wdata = wdata_q;
   assign mem_wmask = wmask_q;

   // Data fans out unqualified; each resp_valid says whose it is.
   assign ifu_rdata = mem_rdata;
   assign lsu_rdata = mem_rdata;

endmodule
